reg_mem_2r1w: RTL and testbench
===============================

// Module: reg_mem_2r1w
// PURPOSE
//  Parametrised register memory: one write port, two independent registered read ports (A, B).
//  Write-first bypass on both read ports. Reset-time content initialisation.
//  Background clear sweep: an FSM writes every entry to zero, one entry per cycle.
//  Serves as the simple_cpu register file / data memory, replacing the single-port reg_mem.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits (>=2)
//  ADDR_BITS   5  address width; DEPTH = 2**ADDR_BITS entries (>=1)
//  INIT_MODE   1  reset contents: 0 -> all zero; 1 -> mem[i] = i mod 2**DATA_WIDTH
// PORTS
//  clk        in   1           clock; all state updates on the rising edge
//  rst_n      in   1           asynchronous reset, active-low
//  wen        in   1           write enable
//  waddr      in   ADDR_BITS   write address
//  wdata      in   DATA_WIDTH  write data
//  wr_drop    out  1           1-cycle pulse: the write was discarded because a clear was busy
//  ren_a      in   1           read enable, port A
//  raddr_a    in   ADDR_BITS   read address, port A
//  rdata_a    out  DATA_WIDTH  registered read data, port A
//  rvalid_a   out  1           rdata_a updated this cycle (registered copy of ren_a)
//  ren_b/raddr_b/rdata_b/rvalid_b  port B; identical to port A
//  clr_start  in   1           request a clear sweep (level-sampled on the edge)
//  busy       out  1           clear sweep in progress
//  clr_done   out  1           1-cycle pulse after the last entry has been cleared
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately, no clock needed):
//   - mem initialised per INIT_MODE.
//   - rdata_a/b=0, rvalid_a/b=0, busy=0, clr_done=0, wr_drop=0, FSM=IDLE, sweep counter=0.
//  Write: if wen=1 and busy=0 at an edge, mem[waddr]<=wdata. Write latency is 1 edge.
//  Read: if ren_x=1 at an edge, rdata_x<=mem[raddr_x]. Latency is 1 edge.
//   - rvalid_x<=ren_x.
//   - If ren_x=0, rdata_x holds its previous value.
//  Bypass (write-first): the write-port term applies only when the write is accepted.
//   - If a write to raddr_x is accepted on the same edge, rdata_x<=wdata.
//   - If the sweep clears raddr_x on the same edge, rdata_x<=0.
//   - Both ports may read the same address simultaneously; both get the same value.
//  FSM states: IDLE, CLEAR, DONE.
//   - IDLE: clr_start=1 -> CLEAR, counter<=0, busy<=1.
//   - CLEAR: each edge mem[counter]<=0 and counter++.
//     At counter==DEPTH-1: write the final entry, go to DONE, busy<=0.
//   - DONE: clr_done=1 for exactly 1 cycle -> IDLE. clr_start is ignored in DONE.
//   - The sweep takes DEPTH edges. busy is high for exactly DEPTH cycles.
//  Boundary rules:
//   - wen=1 while busy=1: write discarded, wr_drop=1 on the next cycle; mem unchanged.
//   - wen=1 and clr_start=1 on the same IDLE edge: write accepted (busy still 0).
//     The sweep then overwrites that entry with zero.
//   - clr_start while busy or in DONE: ignored. No queued second sweep.
//   - Reads during a sweep: allowed. Entries not yet reached return their old data.
//   - Counter wraps at DEPTH-1 only via the DONE exit. Addresses never exceed DEPTH-1.
//   - rst_n low mid-sweep: sweep aborted, contents reinitialised, no clr_done pulse.
//   - DATA_WIDTH < ADDR_BITS with INIT_MODE=1: index value truncated to DATA_WIDTH bits.
// TESTING
//  1. Reset with INIT_MODE=1, then ren_a=1, raddr_a=3 -> next cycle rdata_a=3, rvalid_a=1.
//  2. Write 10..41 to addr 0..31, then read back on A (ascending) and B (descending)
//     -> A returns addr+10; B returns (31-k)+10; each 1 cycle after its ren.
//  3. Same edge: wen=1, waddr=7, wdata=8'hA5, ren_a=1, raddr_a=7 -> rdata_a=8'hA5 next cycle.
//  4. Pulse clr_start -> busy high for exactly 32 cycles, then clr_done high for 1 cycle.
//     Full readback returns all 0.
//  5. Mid-sweep (counter=5): wen=1, waddr=20, wdata=8'h3C -> wr_drop pulses.
//     After the sweep, mem[20]=0.
//     Before the sweep reaches 20, a read of addr 20 returns its old value.
//  6. rst_n=0 at sweep counter=10 -> busy=0 immediately, no clr_done pulse.
//     A read of addr 25 returns 25 (INIT_MODE=1).

Source files
------------

// File: rtl/reg_mem_2r1w.sv
// reg_mem_2r1w: register memory with one write port and two registered read
// ports (A, B). Both read ports are write-first: a write or sweep-clear landing
// on the read address in the same edge is forwarded to the read data.
// A background sweep FSM zeroes one entry per cycle after a clr_start request.
// Asynchronous reset reloads the contents (zero or index pattern) and aborts
// any sweep in progress.
module reg_mem_2r1w #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5,
   parameter int INIT_MODE  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wen,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  wr_drop,
   input  logic                  ren_a,
   input  logic [ADDR_BITS-1:0]  raddr_a,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic                  rvalid_a,
   input  logic                  ren_b,
   input  logic [ADDR_BITS-1:0]  raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  rvalid_b,
   input  logic                  clr_start,
   output logic                  busy,
   output logic                  clr_done
);

   localparam int                    DEPTH     = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(DEPTH - 1);
   localparam logic [ADDR_BITS-1:0]  ZERO_ADDR = {ADDR_BITS{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Reset content of entry idx; the index is truncated when the word is narrower.
   function automatic logic [DATA_WIDTH-1:0] init_word(input int idx);
      if (INIT_MODE == 1) begin
         init_word = DATA_WIDTH'(idx);
      end else begin
         init_word = ZERO_WORD;
      end
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_BITS-1:0]  cnt_r;
   logic [ADDR_BITS-1:0]  cnt_s;
   logic                  busy_r;
   logic                  busy_s;
   logic                  clr_done_r;
   logic                  clr_done_s;
   logic                  wr_drop_r;

   logic                  wr_acc_s;
   logic                  sweep_we_s;
   logic [DATA_WIDTH-1:0] rd_a_s;
   logic [DATA_WIDTH-1:0] rd_b_s;
   logic [DATA_WIDTH-1:0] rdata_a_r;
   logic [DATA_WIDTH-1:0] rdata_b_r;
   logic                  rvalid_a_r;
   logic                  rvalid_b_r;

   // A write is accepted only while no sweep owns the array; the sweep writes in CLEAR.
   always_comb begin
      wr_acc_s   = wen & ~busy_r;
      sweep_we_s = (state_r == ST_CLEAR);
   end

   // Write-first read selection for both ports: accepted write, then sweep clear, then array.
   always_comb begin
      rd_a_s = mem_r[raddr_a];
      rd_b_s = mem_r[raddr_b];
      if (wr_acc_s && (waddr == raddr_a)) begin
         rd_a_s = wdata;
      end else if (sweep_we_s && (cnt_r == raddr_a)) begin
         rd_a_s = ZERO_WORD;
      end else begin
         rd_a_s = mem_r[raddr_a];
      end
      if (wr_acc_s && (waddr == raddr_b)) begin
         rd_b_s = wdata;
      end else if (sweep_we_s && (cnt_r == raddr_b)) begin
         rd_b_s = ZERO_WORD;
      end else begin
         rd_b_s = mem_r[raddr_b];
      end
   end

   // Sweep FSM next-state logic; clr_start is only honoured in IDLE.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      busy_s     = busy_r;
      clr_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (clr_start) begin
               state_s = ST_CLEAR;
               cnt_s   = ZERO_ADDR;
               busy_s  = 1'b1;
            end else begin
               busy_s  = 1'b0;
            end
         end
         ST_CLEAR: begin
            if (cnt_r == LAST_ADDR) begin
               state_s    = ST_DONE;
               busy_s     = 1'b0;
               clr_done_s = 1'b1;
            end else begin
               cnt_s  = cnt_r + ADDR_BITS'(1);
               busy_s = 1'b1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            cnt_s   = ZERO_ADDR;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = ZERO_ADDR;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Sweep FSM state, counter and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= ZERO_ADDR;
         busy_r     <= 1'b0;
         clr_done_r <= 1'b0;
         wr_drop_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         busy_r     <= busy_s;
         clr_done_r <= clr_done_s;
         wr_drop_r  <= wen & busy_r;
      end
   end

   // Storage array: reset reload, accepted writes, and sweep clears (never both at once).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[ADDR_BITS'(i)] <= init_word(i);
         end
      end else if (wr_acc_s) begin
         mem_r[waddr] <= wdata;
      end else if (sweep_we_s) begin
         mem_r[cnt_r] <= ZERO_WORD;
      end
   end

   // Registered read ports; data holds when the port is not enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_r  <= ZERO_WORD;
         rdata_b_r  <= ZERO_WORD;
         rvalid_a_r <= 1'b0;
         rvalid_b_r <= 1'b0;
      end else begin
         rvalid_a_r <= ren_a;
         rvalid_b_r <= ren_b;
         if (ren_a) begin
            rdata_a_r <= rd_a_s;
         end
         if (ren_b) begin
            rdata_b_r <= rd_b_s;
         end
      end
   end

   assign rdata_a  = rdata_a_r;
   assign rdata_b  = rdata_b_r;
   assign rvalid_a = rvalid_a_r;
   assign rvalid_b = rvalid_b_r;
   assign busy     = busy_r;
   assign clr_done = clr_done_r;
   assign wr_drop  = wr_drop_r;

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Bench for reg_mem_2r1w: a reference memory/sweep model predicts every read
// (pushed to per-port queues at drive time, popped after the edge), plus a
// vector table with hand-computed results and hand-written sweep/reset sequences.
module tb_reg_mem_2r1w;

   localparam int DEPTH = 32;

   logic       clk;
   logic       rst_n;
   logic       wen;
   logic [4:0] waddr;
   logic [7:0] wdata;
   logic       wr_drop;
   logic       ren_a;
   logic [4:0] raddr_a;
   logic [7:0] rdata_a;
   logic       rvalid_a;
   logic       ren_b;
   logic [4:0] raddr_b;
   logic [7:0] rdata_b;
   logic       rvalid_b;
   logic       clr_start;
   logic       busy;
   logic       clr_done;

   reg_mem_2r1w #(.DATA_WIDTH(8), .ADDR_BITS(5), .INIT_MODE(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .wen(wen), .waddr(waddr), .wdata(wdata), .wr_drop(wr_drop),
      .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
      .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
      .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   // reference model
   logic [7:0] m_mem [DEPTH];
   int         m_phase;   // 0 idle, 1 clearing, 2 done
   logic [4:0] m_cnt;
   logic       m_busy;
   logic       m_done;
   logic       m_drop;
   logic [7:0] last_a;
   logic [7:0] last_b;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   typedef struct {
      logic       w;
      logic [4:0] wa;
      logic [7:0] wd;
      logic       rea;
      logic [4:0] ra;
      logic       reb;
      logic [4:0] rb;
      logic [7:0] ea;
      logic [7:0] eb;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'(i);
      m_phase = 0;
      m_cnt   = 5'd0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_drop  = 1'b0;
      last_a  = 8'h00;
      last_b  = 8'h00;
      q_a.delete();
      q_b.delete();
   endtask

   task automatic step(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                       input logic rea, input logic [4:0] ra,
                       input logic reb, input logic [4:0] rb, input logic cs);
      logic       acc;
      logic       sweep;
      logic [7:0] ea;
      logic [7:0] eb;
      @(negedge clk);
      wen = w; waddr = wa; wdata = wd;
      ren_a = rea; raddr_a = ra; ren_b = reb; raddr_b = rb; clr_start = cs;
      acc   = w && !m_busy;
      sweep = (m_phase == 1);
      if (acc && wa == ra) ea = wd;
      else if (sweep && m_cnt == ra) ea = 8'h00;
      else ea = m_mem[ra];
      if (acc && wa == rb) eb = wd;
      else if (sweep && m_cnt == rb) eb = 8'h00;
      else eb = m_mem[rb];
      if (rea) q_a.push_back(ea);
      if (reb) q_b.push_back(eb);
      m_drop = w && m_busy;
      if (acc) m_mem[wa] = wd;
      else if (sweep) m_mem[m_cnt] = 8'h00;
      m_done = 1'b0;
      if (m_phase == 0) begin
         if (cs) begin m_phase = 1; m_cnt = 5'd0; m_busy = 1'b1; end
      end else if (m_phase == 1) begin
         if (m_cnt == 5'd31) begin m_phase = 2; m_busy = 1'b0; m_done = 1'b1; end
         else m_cnt = m_cnt + 5'd1;
      end else begin
         m_phase = 0; m_cnt = 5'd0;
      end
      @(posedge clk);
      #1;
      chk("rvalid_a", 32'(rvalid_a), 32'(rea));
      chk("rvalid_b", 32'(rvalid_b), 32'(reb));
      if (rea && q_a.size() > 0) last_a = q_a.pop_front();
      if (reb && q_b.size() > 0) last_b = q_b.pop_front();
      chk("rdata_a", 32'(rdata_a), 32'(last_a));
      chk("rdata_b", 32'(rdata_b), 32'(last_b));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("clr_done", 32'(clr_done), 32'(m_done));
      chk("wr_drop", 32'(wr_drop), 32'(m_drop));
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdata_a"}, 32'(rdata_a), 32'h0);
      chk({tag, "_rdata_b"}, 32'(rdata_b), 32'h0);
      chk({tag, "_rvalid_a"}, 32'(rvalid_a), 32'h0);
      chk({tag, "_rvalid_b"}, 32'(rvalid_b), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_clr_done"}, 32'(clr_done), 32'h0);
      chk({tag, "_wr_drop"}, 32'(wr_drop), 32'h0);
   endtask

   initial begin
      int n_busy;
      int n_done;
      n_chk = 0;
      n_fail = 0;
      vecs[0] = '{1'b0, 5'd0, 8'h00, 1'b1, 5'd3,  1'b1, 5'd31, 8'h03, 8'h1F};
      vecs[1] = '{1'b1, 5'd7, 8'hA5, 1'b1, 5'd7,  1'b1, 5'd7,  8'hA5, 8'hA5};
      vecs[2] = '{1'b0, 5'd0, 8'h00, 1'b1, 5'd7,  1'b1, 5'd6,  8'hA5, 8'h06};
      vecs[3] = '{1'b1, 5'd0, 8'hFF, 1'b0, 5'd0,  1'b1, 5'd0,  8'hA5, 8'hFF};
      vecs[4] = '{1'b0, 5'd0, 8'h00, 1'b1, 5'd0,  1'b0, 5'd0,  8'hFF, 8'hFF};

      // reset state, checked before any clock edge
      rst_n = 1'b0; wen = 1'b0; waddr = 5'd0; wdata = 8'h00;
      ren_a = 1'b0; raddr_a = 5'd0; ren_b = 1'b0; raddr_b = 5'd0; clr_start = 1'b0;
      model_reset();
      #2;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // table: init read, same-edge bypass on both ports, hold when not enabled
      for (int i = 0; i < 5; i++) begin
         step(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].rea, vecs[i].ra,
              vecs[i].reb, vecs[i].rb, 1'b0);
         chk($sformatf("vec%0d_a", i), 32'(rdata_a), 32'(vecs[i].ea));
         chk($sformatf("vec%0d_b", i), 32'(rdata_b), 32'(vecs[i].eb));
      end

      // fill addr k with k+10, read back ascending on A and descending on B
      for (int k = 0; k < DEPTH; k++) step(1'b1, 5'(k), 8'(k + 10), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b0, 5'd0, 8'h00, 1'b1, 5'(k), 1'b1, 5'(31 - k), 1'b0);
         chk("fill_a", 32'(rdata_a), 32'(k + 10));
         chk("fill_b", 32'(rdata_b), 32'((31 - k) + 10));
      end

      // sweep started on the same edge as an accepted write to addr 9
      step(1'b1, 5'd9, 8'h77, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      chk("start_no_drop", 32'(wr_drop), 32'h0);
      n_busy = busy ? 1 : 0;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         if (busy) n_busy++;
         if (clr_done) n_done++;
      end
      chk("busy_cycles", 32'(n_busy), 32'(DEPTH));
      chk("done_pulses", 32'(n_done), 32'd1);
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b0, 5'd0, 8'h00, 1'b1, 5'(k), 1'b1, 5'(k), 1'b0);
         chk("cleared_a", 32'(rdata_a), 32'h0);
      end

      // dropped write mid-sweep, old data before the sweep arrives, ignored restarts
      step(1'b1, 5'd20, 8'h55, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      for (int i = 0; i < 40 && m_cnt != 5'd5; i++) idle();
      step(1'b1, 5'd20, 8'h3C, 1'b1, 5'd20, 1'b0, 5'd0, 1'b0);
      chk("mid_wr_drop", 32'(wr_drop), 32'h1);
      chk("mid_old_20", 32'(rdata_a), 32'h55);
      step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      chk("restart_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 40 && m_phase != 2; i++) idle();
      step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      chk("done_ignores_start", 32'(busy), 32'h0);
      idle();
      chk("no_second_sweep", 32'(busy), 32'h0);
      step(1'b0, 5'd0, 8'h00, 1'b1, 5'd20, 1'b0, 5'd0, 1'b0);
      chk("after_sweep_20", 32'(rdata_a), 32'h0);

      // reset in the middle of a sweep
      step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      for (int i = 0; i < 40 && m_cnt != 5'd10; i++) idle();
      chk("pre_abort_busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         if (clr_done) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'h0);
      step(1'b0, 5'd0, 8'h00, 1'b1, 5'd25, 1'b1, 5'd9, 1'b0);
      chk("abort_reinit_25", 32'(rdata_a), 32'd25);
      chk("abort_reinit_9", 32'(rdata_b), 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
